sha3_scan_dispatcher: RTL
=========================

Name: sha3_scan_dispatcher

Overview:
- Initiator-side companion of the SHA3 scanner core. It owns the block template and threshold registers and drives start/threshold/blobby into the scanner.
- Runs a programmed number of back-to-back scans and increments a nonce-high template word between scans.
- Collects found hash/nonce pulses into a small result FIFO with a valid/ready output.
- Sits between the register/control layer and the scanner instance.

Parameters:
- RESULT_DEPTH, 2, result FIFO entries; power of two, 2..8.
- NONCE_HI_WORD, 23, index of the blobby word incremented by 1 after each completed scan.
- START_TIMEOUT, 255, cycles to wait for dispatching after start before flagging an error.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  5  0..23 = blobby word, 24 = threshold[31:0], 25 = threshold[63:32]; others ignored.
- cfg_data  in  32  write data.
- cfg_err  out  1  one-cycle pulse: write rejected because busy.
- cmd_go  in  1  pulse: begin a job.
- cmd_rounds  in  16  number of scans, sampled on cmd_go.
- cmd_abort  in  1  pulse: finish the current scan, start no more.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- timeout_err  out  1  sticky; cleared on cmd_go.
- scans_done  out  16  completed scans in the current or last job.
- dropped  out  8  saturating count of found results lost to a full FIFO; cleared on cmd_go.
- start  out  1  to scanner.
- threshold  out  64  to scanner.
- blobby  out  32x24  to scanner, unpacked array [24].
- dispatching, evaluating, ready, found  in  1 each  from scanner.
- hash  in  32x50  from scanner.
- nonce  in  32  from scanner.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  consumer pop.
- res_hash  out  32x50  FIFO head.
- res_nonce  out  32  FIFO head.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0; template, threshold and counters 0; FIFO empty; state IDLE.
  - Reset mid-job abandons the job with no done pulse.
- Config:
  - Write lands one cycle after cfg_we, only in IDLE or DONE.
  - A write in any other state is discarded and cfg_err pulses the next cycle.
- FSM states: IDLE, ARM, START, WAIT_BUSY, RUN, NEXT, DONE.
- IDLE:
  - cmd_go with cmd_rounds != 0: latch rounds, clear scans_done/dropped/timeout_err, busy=1, go to ARM.
  - cmd_go with cmd_rounds == 0: done pulses the next cycle, busy stays 0, no start issued.
- ARM: wait for ready=1, then go to START.
- START: start=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY:
  - On dispatching=1 go to RUN.
  - After START_TIMEOUT cycles without it: set timeout_err, go to DONE.
- RUN: wait for dispatching=0 and evaluating=0 in the same cycle, then go to NEXT.
- NEXT:
  - scans_done += 1.
  - blobby[NONCE_HI_WORD] += 1 (wraps mod 2^32).
  - If scans_done == rounds or an abort is pending, go to DONE; else go to ARM.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- cmd_go while busy is ignored.
- cmd_abort:
  - Latched as pending in ARM through NEXT; cleared on entering IDLE.
  - In ARM, an abort goes directly to DONE with no start.
  - The running scan is never cut short.
- Results: a found pulse in any state pushes {hash, nonce} when the FIFO is not full. With the FIFO full it:
  - drops the result and increments dropped (saturates at 255);
  - is accepted, not dropped, if a pop happens in the same cycle.
- FIFO:
  - Push and pop in the same cycle keep occupancy unchanged.
  - Pop on empty is ignored.
  - Head is registered; res_valid rises 1 cycle after the push into an empty FIFO.
  - Pointers wrap mod RESULT_DEPTH.
- Results keep flowing after done; the FIFO is not cleared by cmd_go.

Decomposition:
- Package sha3_scan_pkg:
  - BLOB_WORDS=24, HASH_WORDS=50;
  - cfg address constants;
  - typedef scan_result_t {hash[50], nonce};
  - dispatcher state enum.
- One sub-module: sha3_scan_result_fifo (parameter RESULT_DEPTH, scan_result_t, push/pop/full/empty).

Test Plan:
- Program the template with word i = i, threshold = 64'h0000_0FFF_FFFF_FFFF, cmd_rounds=3, using a scanner model with a 10-cycle dispatch and a 4-cycle evaluate -> exactly 3 start pulses, blobby[23] ends at 26, scans_done=3, one done pulse.
- cfg_we to addr 5 while busy -> cfg_err pulses and word 5 is unchanged; the same write in IDLE -> word 5 updates the next cycle.
- Model emits 4 found pulses with res_ready=0 and RESULT_DEPTH=2 -> res_valid=1, dropped=2, and pops return the first two nonces in order.
- found while full with res_ready=1 in the same cycle -> no drop and occupancy stays at 2.
- cmd_abort during RUN of scan 1 of 5 -> no second start, done pulses, scans_done=1; cmd_rounds=0 -> done without start.
- Model never raises dispatching -> timeout_err=1 after 255 cycles, then done; assert S_AXI_ARESETN=0 mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/sha3_scan_pkg.sv
// rtl/sha3_scan_pkg.sv - shared constants, types and state encoding for the SHA3 scan dispatcher
package sha3_scan_pkg;

  localparam int BLOB_WORDS = 24;
  localparam int HASH_WORDS = 50;

  // Config address map: 0..BLOB_WORDS-1 address template words directly
  localparam logic [4:0] CFG_THR_LO = 5'd24;
  localparam logic [4:0] CFG_THR_HI = 5'd25;

  typedef struct packed {
    logic [HASH_WORDS-1:0][31:0] hash;
    logic [31:0]                 nonce;
  } scan_result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } disp_state_t;

  // Template and threshold may only change while no scan is in flight
  function automatic logic cfg_open(disp_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/sha3_scan_dispatcher_if.sv
// rtl/sha3_scan_dispatcher_if.sv - link between the dispatcher and the SHA3 scanner core
interface sha3_scan_dispatcher_if;
  import sha3_scan_pkg::*;

  logic        start;
  logic [63:0] threshold;
  logic [31:0] blobby [BLOB_WORDS];
  logic        dispatching;
  logic        evaluating;
  logic        ready;
  logic        found;
  logic [31:0] hash [HASH_WORDS];
  logic [31:0] nonce;

  modport master (
    output start, threshold, blobby,
    input  dispatching, evaluating, ready, found, hash, nonce
  );

  modport slave (
    input  start, threshold, blobby,
    output dispatching, evaluating, ready, found, hash, nonce
  );

endinterface

// File: rtl/sha3_scan_result_fifo.sv
// rtl/sha3_scan_result_fifo.sv - small result FIFO with registered storage and same-cycle push/pop
module sha3_scan_result_fifo
  import sha3_scan_pkg::*;
#(
  parameter int RESULT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  scan_result_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output scan_result_t head
);

  localparam int PW = $clog2(RESULT_DEPTH);
  localparam int CW = PW + 1;

  scan_result_t      mem [RESULT_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CW'(RESULT_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage and pointers; pointer width makes wrap mod RESULT_DEPTH implicit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESULT_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha3_scan_dispatcher.sv
// rtl/sha3_scan_dispatcher.sv - runs back-to-back scanner jobs and collects found results
module sha3_scan_dispatcher
  import sha3_scan_pkg::*;
#(
  parameter int RESULT_DEPTH  = 2,
  parameter int NONCE_HI_WORD = 23,
  parameter int START_TIMEOUT = 255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_err,
  input  logic        cmd_go,
  input  logic [15:0] cmd_rounds,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] scans_done,
  output logic [7:0]  dropped,
  sha3_scan_dispatcher_if.master scan,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_hash [HASH_WORDS],
  output logic [31:0] res_nonce
);

  localparam int            TW       = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  disp_state_t   state;
  disp_state_t   state_nx;
  logic [15:0]   rounds_q;
  logic [15:0]   scans_inc;
  logic          abort_pend;
  logic          abort_any;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          go_idle;
  logic          start_o;
  logic [31:0]   blob_q [BLOB_WORDS];
  logic [63:0]   thr_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          res_pop;
  logic          drop;
  scan_result_t  push_data;
  scan_result_t  head;

  assign go_idle   = (state == ST_IDLE) && cmd_go;
  assign abort_any = abort_pend || cmd_abort;
  assign scans_inc = scans_done + 16'd1;
  assign tmo_hit   = (state == ST_WAIT_BUSY) && !scan.dispatching && (tmo_cnt == TMO_LAST);
  assign res_pop   = res_ready && !fifo_empty;
  assign drop      = scan.found && fifo_full && !res_pop;

  assign scan.start     = start_o;
  assign scan.threshold = thr_q;
  assign scan.blobby    = blob_q;

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= ST_IDLE;
    else                state <= state_nx;
  end

  // Next-state logic; an abort only cuts in before a scan starts, never during one
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:      if (cmd_go) state_nx = (cmd_rounds == 16'd0) ? ST_DONE : ST_ARM;
      ST_ARM: begin
        if (abort_any)       state_nx = ST_DONE;
        else if (scan.ready) state_nx = ST_START;
      end
      ST_START:     state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (scan.dispatching) state_nx = ST_RUN;
        else if (tmo_hit)     state_nx = ST_DONE;
      end
      ST_RUN:       if (!scan.dispatching && !scan.evaluating) state_nx = ST_NEXT;
      ST_NEXT:      state_nx = ((scans_inc == rounds_q) || abort_any) ? ST_DONE : ST_ARM;
      ST_DONE:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    start_o = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_ARM, ST_WAIT_BUSY, ST_RUN, ST_NEXT: busy = 1'b1;
      ST_START: begin
        busy    = 1'b1;
        start_o = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Job bookkeeping: round count, scan counter, abort latch, dispatch watchdog
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rounds_q    <= '0;
      scans_done  <= '0;
      timeout_err <= 1'b0;
      abort_pend  <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      if (go_idle) begin
        rounds_q    <= cmd_rounds;
        scans_done  <= '0;
        timeout_err <= 1'b0;
      end
      if (state == ST_NEXT) scans_done <= scans_inc;
      if (tmo_hit) timeout_err <= 1'b1;
      if (state == ST_START)          tmo_cnt <= '0;
      else if (state == ST_WAIT_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
      if (cfg_open(state)) abort_pend <= 1'b0;
      else if (cmd_abort)  abort_pend <= 1'b1;
    end
  end

  // Template/threshold registers; writes outside IDLE/DONE are refused with cfg_err
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cfg_err <= 1'b0;
      thr_q   <= '0;
      for (int i = 0; i < BLOB_WORDS; i++) blob_q[i] <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_open(state);
      if (cfg_we && cfg_open(state)) begin
        if (cfg_addr < 5'(BLOB_WORDS)) blob_q[cfg_addr] <= cfg_data;
        else if (cfg_addr == CFG_THR_LO) thr_q[31:0]  <= cfg_data;
        else if (cfg_addr == CFG_THR_HI) thr_q[63:32] <= cfg_data;
      end
      if (state == ST_NEXT) blob_q[NONCE_HI_WORD] <= blob_q[NONCE_HI_WORD] + 32'd1;
    end
  end

  // Saturating count of results lost to a full FIFO
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                 dropped <= '0;
    else if (go_idle)                   dropped <= '0;
    else if (drop && dropped != 8'hFF)  dropped <= dropped + 8'd1;
  end

  // Pack the scanner's result words into one FIFO entry
  always_comb begin
    push_data       = '0;
    push_data.nonce = scan.nonce;
    for (int i = 0; i < HASH_WORDS; i++) push_data.hash[i] = scan.hash[i];
  end

  sha3_scan_result_fifo #(
    .RESULT_DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .push      (scan.found),
    .push_data (push_data),
    .pop       (res_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign res_valid = !fifo_empty;
  assign res_nonce = head.nonce;

  // Unpack the FIFO head onto the result hash words
  always_comb begin
    for (int i = 0; i < HASH_WORDS; i++) res_hash[i] = head.hash[i];
  end

endmodule
